// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle data-memory responder. It is the target end of the MEM stage's
//   D-MEM access path. It takes one load/store request at a time, performs the
//   access LATENCY cycles after accepting it, and returns a response.
//
//   Timing: a request accepted at edge N raises rsp_valid after edge N+LATENCY.
//   The response is held until rsp_valid & rsp_ready. req_ready rises on the
//   cycle after that handshake, so a request and a response never overlap.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   req_valid  in   1      request present
//   req_ready  out  1      responder idle and able to accept a request
//   req_we     in   1      1 = store, 0 = load
//   req_addr   in   DBITS  byte address; bits above DMEMADDRBITS alias
//   req_wdata  in   DBITS  store data
//   req_be     in   4      byte enables (only honoured with DMEM_BYTE_WRITE_EN)
//   rsp_valid  out  1      response present
//   rsp_ready  in   1      MEM stage takes the response
//   rsp_we     out  1      echo of the accepted req_we
//   rsp_rdata  out  DBITS  load data; 0 for stores
//
// Configuration macro
//   DMEM_BYTE_WRITE_EN  defined: a store writes only the bytes whose req_be bit
//                       is set, and be=0 completes without writing.
//                       undefined: req_be is ignored and stores write full words.
//
// Storage is not cleared by reset. The IDMEMINITFILE image is loaded into
// `mem` by the enclosing simulation or FPGA wrapper.
// LATENCY legal range: 1..15.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DBITS        = 32,
  parameter int DMEMADDRBITS = 16,
  parameter int DMEMWORDBITS = 2,
  parameter int LATENCY      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [DBITS-1:0] req_addr,
  input  logic [DBITS-1:0] req_wdata,
  input  logic [3:0]       req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_we,
  output logic [DBITS-1:0] rsp_rdata
);

  localparam int IDXBITS = DMEMADDRBITS - DMEMWORDBITS;
  localparam int NWORDS  = 1 << IDXBITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [3:0]         cnt_q;
  logic               we_q;
  logic [IDXBITS-1:0] idx_q;
  logic [DBITS-1:0]   wdata_q;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]         be_q;
`endif

  logic [DBITS-1:0]   mem [NWORDS];

  logic accept;
  logic do_access;

  // req_be is meaningful only in the byte-write build. The byte-offset bits and
  // the aliased upper bits of req_addr are never decoded.
  logic unused_req;
  assign unused_req = ^{req_be, req_addr};

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;
  // The counter runs down from LATENCY-1, so the access happens at edge
  // N+LATENCY for a request accepted at edge N.
  assign do_access = (state_q == WAIT) && (cnt_q == '0);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = WAIT;
      WAIT:    if (do_access) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Request capture, latency counter and response registers. A reset drops any
  // captured request, so a pending store never reaches the memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
`ifdef DMEM_BYTE_WRITE_EN
      be_q      <= '0;
`endif
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= 4'(LATENCY - 1);
        we_q    <= req_we;
        idx_q   <= req_addr[DMEMADDRBITS-1:DMEMWORDBITS];
        wdata_q <= req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
        be_q    <= req_be;
`endif
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end

      // The access happens once, on the WAIT->RESP edge. Back-pressure in RESP
      // only holds these registers.
      if (do_access) begin
        rsp_we    <= we_q;
        rsp_rdata <= we_q ? '0 : mem[idx_q];
      end
    end
  end

  // Storage write port. The store commits on the same edge that enters RESP,
  // so a following load always sees it.
  // NOTE: the memory array has no reset. Clearing it would prevent RAM
  // inference and would wipe the preloaded image.
  always_ff @(posedge clk) begin
    if (do_access && we_q) begin
`ifdef DMEM_BYTE_WRITE_EN
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
`else
      mem[idx_q] <= wdata_q;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder. Each accepted request pushes its
//   expected response, taken from a word-indexed reference model, onto a queue.
//   The entry is popped and compared when the DUT presents the response.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_we;
  logic [31:0] rsp_rdata;

  typedef struct {
    logic        we;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] model [int];
  int          total = 0;
  int          bad   = 0;

  dmem_responder #(
    .DBITS        (32),
    .DMEMADDRBITS (16),
    .DMEMWORDBITS (2),
    .LATENCY      (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_rdata (rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference store merge: honours byte enables only in the byte-write build.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    logic [3:0]  en;
`ifdef DMEM_BYTE_WRITE_EN
    en = be;
`else
    en = 4'hF;
`endif
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  // One complete transaction. Called on a falling edge and returns on a falling
  // edge. hold > 0 keeps rsp_ready low for that many cycles in RESP, pulsing a
  // stray store that must be ignored.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold);
    int          k;
    int          idx;
    rsp_t        e;
    logic [31:0] old;
    idx       = int'(addr[15:2]);
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_wait", {31'b0, req_ready}, 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);  // request accepted on this edge
    if (we) begin
      old        = model.exists(idx) ? model[idx] : 32'h0;
      model[idx] = merge(old, wdata, be);
      e.we       = 1'b1;
      e.data     = 32'h0;
    end else begin
      e.we   = 1'b0;
      e.data = model.exists(idx) ? model[idx] : 32'h0;
    end
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, LAT);
    if (!rsp_valid) return;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check("hold_rdata", rsp_rdata, sb[0].data);
      req_valid = (i % 2 == 0);
      req_we    = 1'b1;
      req_addr  = 32'h200;
      req_wdata = 32'hBAD0BAD0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("sb_size", sb.size(), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_we", {31'b0, rsp_we}, {31'b0, e.we});
      check("rsp_rdata", rsp_rdata, e.data);
    end
    rsp_ready = 1'b1;
    @(posedge clk);  // response handshake
    @(negedge clk);
    check("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int          idx;

    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_we", {31'b0, rsp_we}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Word 0 gets known content, then a load checks the latency and the data.
    xact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0);
    xact(1'b0, 32'h0, 32'h0, 4'hF, 0);

    // Reset in the middle of WAIT with a store to 0x40 pending: the store is dropped.
    xact(1'b1, 32'h40, 32'h600DCAFE, 4'hF, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'hDEADDEAD;
    req_be    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_req_ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    xact(1'b0, 32'h40, 32'h0, 4'hF, 0);

    // Store followed by a load to the same word.
    xact(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0);
    xact(1'b0, 32'h100, 32'h0, 4'hF, 0);

    // Address aliasing above DMEMADDRBITS.
    xact(1'b1, 32'h00010004, 32'h00000055, 4'hF, 0);
    xact(1'b0, 32'h00000004, 32'h0, 4'hF, 0);

    // Back-pressure for 10 cycles while stray stores to 0x200 are pulsed.
    xact(1'b1, 32'h200, 32'h00001234, 4'hF, 0);
    xact(1'b0, 32'h100, 32'h0, 4'hF, 10);
    xact(1'b0, 32'h200, 32'h0, 4'hF, 0);

    // Byte enables: the result depends on DMEM_BYTE_WRITE_EN.
    xact(1'b1, 32'h300, 32'h11223344, 4'hF, 0);
    xact(1'b1, 32'h300, 32'hAABBCCDD, 4'b0101, 0);
    xact(1'b0, 32'h300, 32'h0, 4'hF, 0);
`ifdef DMEM_BYTE_WRITE_EN
    check("be_result", model[int'(32'h300 >> 2)], 32'h11BB33DD);
`else
    check("be_result", model[int'(32'h300 >> 2)], 32'hAABBCCDD);
`endif

    // Random traffic over 16 words with random aliased upper bits and offsets.
    for (int i = 0; i < 16; i++) begin
      xact(1'b1, 32'h800 + 32'(4 * i), $urandom(), 4'hF, 0);
    end
    for (int i = 0; i < 30; i++) begin
      r   = $urandom();
      idx = int'($urandom_range(15, 0));
      a   = (r & 32'hFFFF0000) | (32'h800 + 32'(4 * idx)) | (r & 32'h3);
      xact(r[8], a, $urandom(), r[7:4], (i % 7 == 3) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
